jt51_slot_wr: RTL and testbench
===============================

Name: jt51_slot_wr

Overview:
- Parametrised slot sequencer and write scheduler for the time-multiplexed FM operator pipeline.
- Owns the slot counter (operator-major, channel-minor) and a small write FIFO.
- Applies each queued register write when its target slot reaches the requested pipeline stage, so per-stage CSR banks see a one-cen commit strobe.
- Adds queued writes and broadcast writes to all channels of an operator, with configurable channel/operator counts.

Parameters:
- CH_W, 3, channel index width (2^CH_W channels)
- OP_W, 2, operator index width (2^OP_W operators)
- DW, 8, data width
- FLD_W, 4, register field selector width
- STG_W, 3, stage offset width (offsets 0..2^STG_W-1)
- FIFO_AW, 2, FIFO address width (depth 2^FIFO_AW)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cen  in  1  pipeline clock enable; one slot per cen
- wr_valid  in  1  host write request
- wr_ready  out  1  FIFO not full
- wr_fld  in  FLD_W  field selector
- wr_op  in  OP_W  target operator
- wr_ch  in  CH_W  target channel
- wr_stage  in  STG_W  stage offset at which the field is consumed
- wr_all  in  1  broadcast to every channel of wr_op
- wr_din  in  DW  data
- cur_op  out  OP_W  current slot operator, cur[SW-1:CH_W]
- cur_ch  out  CH_W  current slot channel, cur[CH_W-1:0]
- zero  out  1  registered: next slot is 0
- commit  out  1  one-cycle commit strobe (registered)
- commit_fld  out  FLD_W  field of committed write
- commit_din  out  DW  data of committed write
- busy  out  1  FIFO non-empty or commit in flight
- level  out  FIFO_AW+1  FIFO occupancy

Behaviour:
- SW = CH_W+OP_W; NSLOT = 2^SW.
- cur (SW bits) increments by 1 on each clk edge with cen, wrapping NSLOT-1 -> 0.
- zero <= (cur+1 == 0) on cen.
- Reset values: cur=0, zero=0, commit=0, commit_fld=0, commit_din=0, FIFO empty, level=0, busy=0, wr_ready=1, bcast_cnt=0.
- Push on any clk edge with wr_valid && wr_ready; push is not gated by cen. Entry = {fld, op, ch, stage, all, din}.
- wr_ready = (level != 2^FIFO_AW), combinational from registered level.
- Target slot, unicast: tgt = {op, ch} + stage, mod NSLOT.
- Target slot, broadcast: tgt = {op, bcast_cnt} + stage, mod NSLOT; bcast_cnt is an internal CH_W counter.
- Match on a cen edge when FIFO is non-empty and cur == tgt of the head entry:
  - commit <= 1; commit_fld/commit_din <= head fields.
  - Unicast: pop.
  - Broadcast: bcast_cnt += 1; pop only when bcast_cnt == 2^CH_W-1, then bcast_cnt <= 0. A broadcast therefore emits 2^CH_W commits on consecutive cen cycles.
- On every other edge: commit <= 0. commit_fld/commit_din hold their last value.
- Latency:
  - An entry pushed at edge t is head-visible at t+1.
  - First possible commit edge is the first cen edge at or after t+1 where cur matches.
  - Worst case is NSLOT cen cycles after reaching head.
- At most one commit per cen; FIFO order is strict (no reordering).
- Simultaneous push and pop: level unchanged. Push is refused only while full; a pop on that edge frees space for the next edge.
- busy = (level != 0) || commit.
- Stage offset wrap: tgt addition wraps modulo NSLOT, e.g. op=3, ch=7, stage=2 -> slot 1.
- cen low: no commit, no cur change; pushes still accepted.
- Reset mid-operation: all queued and partially broadcast entries are discarded; no commit pulse on the cycle rst deasserts.

Test Plan:
- Reset release, cen every cycle -> cur cycles 0..31 and wraps. zero high on the cycle cur=31 is registered, i.e. visible while cur==0.
- Unicast op=1, ch=2, stage=0, din=0x5A pushed while cur=3 -> commit pulses on the cen edge where cur==10; commit_din=0x5A; level returns to 0; busy falls one cycle later.
- Unicast op=3, ch=7, stage=2 -> commit at cur==1, checking wrap of the target slot.
- Broadcast op=2, stage=1, din=0x33 -> 8 commits at cur 17..24 in consecutive cen cycles, then pop.
- Fill FIFO with 4 entries and no match, hold wr_valid=1 -> wr_ready=0, level=4. After the first commit, the fifth write is accepted on the next edge and level stays 4; commit order equals push order.
- Reset during a broadcast after 3 commits -> no further commits, level=0, cur=0. A subsequent broadcast restarts at channel 0.

Source files
------------

// File: rtl/jt51_slot_wr.sv
// jt51_slot_wr: slot sequencer and write scheduler for the time-multiplexed
// FM operator pipeline. Owns the operator-major/channel-minor slot counter
// and a small write FIFO. The head write is released as a one-cen commit
// strobe when the current slot equals its target slot (the write's own slot
// plus a stage offset). Broadcast writes sweep all channels of one operator.
module jt51_slot_wr #(
    parameter int CH_W    = 3,
    parameter int OP_W    = 2,
    parameter int DW      = 8,
    parameter int FLD_W   = 4,
    parameter int STG_W   = 3,
    parameter int FIFO_AW = 2
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [FLD_W-1:0]   wr_fld,
    input  logic [OP_W-1:0]    wr_op,
    input  logic [CH_W-1:0]    wr_ch,
    input  logic [STG_W-1:0]   wr_stage,
    input  logic               wr_all,
    input  logic [DW-1:0]      wr_din,
    output logic [OP_W-1:0]    cur_op,
    output logic [CH_W-1:0]    cur_ch,
    output logic               zero,
    output logic               commit,
    output logic [FLD_W-1:0]   commit_fld,
    output logic [DW-1:0]      commit_din,
    output logic               busy,
    output logic [FIFO_AW:0]   level
);

    localparam int SW    = CH_W + OP_W;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [SW-1:0]      SLOT_ONE = SW'(1);
    localparam logic [CH_W-1:0]    CH_ONE   = CH_W'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);

    typedef struct packed {
        logic [FLD_W-1:0] fld;
        logic [OP_W-1:0]  op;
        logic [CH_W-1:0]  ch;
        logic [STG_W-1:0] stage;
        logic             all;
        logic [DW-1:0]    din;
    } wr_entry_t;

    logic [SW-1:0]      cur;
    logic [CH_W-1:0]    bcast_cnt;
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    wr_entry_t          mem [DEPTH];

    wr_entry_t          wr_ent;
    wr_entry_t          head;
    logic [CH_W-1:0]    head_ch;
    logic [SW-1:0]      tgt;
    logic               empty;
    logic               hit;
    logic               fire;
    logic               last_ch;
    logic               push;
    logic               pop;

    assign cur_op = cur[SW-1:CH_W];
    assign cur_ch = cur[CH_W-1:0];

    assign wr_ent = '{fld: wr_fld, op: wr_op, ch: wr_ch, stage: wr_stage,
                      all: wr_all, din: wr_din};

    // Head entry is only meaningful while the FIFO is non-empty; empty gates hit.
    assign head    = mem[rptr];
    assign empty   = (level == '0);
    assign wr_ready = (level != LVL_FULL);

    // Broadcasts walk the channel field with bcast_cnt instead of the stored channel.
    assign head_ch = head.all ? bcast_cnt : head.ch;

    // Target slot wraps modulo the slot count; the cast truncates or extends the offset.
    assign tgt     = {head.op, head_ch} + SW'(head.stage);

    assign hit     = !empty && (cur == tgt);
    assign fire    = cen && hit;
    assign last_ch = &bcast_cnt;

    // Push is independent of cen; pop only when the entry has emitted all its commits.
    assign push    = wr_valid && wr_ready;
    assign pop     = fire && (!head.all || last_ch);

    assign busy    = !empty || commit;

    // Slot counter advances one slot per cen; zero flags the wrap to slot 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur  <= '0;
            zero <= 1'b0;
        end else if (cen) begin
            cur  <= cur + SLOT_ONE;
            zero <= &cur;
        end
    end

    // FIFO storage; validity is tracked by level, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_ent;
    end

    // FIFO read/write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
        end
    end

    // Occupancy: simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Broadcast channel sweep; returns to channel 0 after the last channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcast_cnt <= '0;
        end else if (fire && head.all) begin
            bcast_cnt <= last_ch ? '0 : bcast_cnt + CH_ONE;
        end
    end

    // Commit strobe lasts one clock; field and data hold until the next commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit     <= 1'b0;
            commit_fld <= '0;
            commit_din <= '0;
        end else begin
            commit <= fire;
            if (fire) begin
                commit_fld <= head.fld;
                commit_din <= head.din;
            end
        end
    end

endmodule

// File: tb/tb_jt51_slot_wr.sv
// Self-checking bench for jt51_slot_wr: directed scenarios plus a randomized
// run against a queue-based reference model of the write scheduler.
module tb_jt51_slot_wr;

    localparam int CH_W = 3, OP_W = 2, DW = 8, FLD_W = 4, STG_W = 3, FIFO_AW = 2;
    localparam int NCH = 1 << CH_W;
    localparam int NSLOT = 1 << (CH_W + OP_W);
    localparam int DEPTH = 1 << FIFO_AW;

    logic clk = 0, rst = 1, cen = 0, wr_valid = 0, wr_all = 0;
    logic wr_ready, zero, commit, busy;
    logic [FLD_W-1:0] wr_fld = 0, commit_fld;
    logic [OP_W-1:0] wr_op = 0, cur_op;
    logic [CH_W-1:0] wr_ch = 0, cur_ch;
    logic [STG_W-1:0] wr_stage = 0;
    logic [DW-1:0] wr_din = 0, commit_din;
    logic [FIFO_AW:0] level;

    jt51_slot_wr #(.CH_W(CH_W), .OP_W(OP_W), .DW(DW), .FLD_W(FLD_W),
                   .STG_W(STG_W), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk), .rst(rst), .cen(cen), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_fld(wr_fld), .wr_op(wr_op), .wr_ch(wr_ch), .wr_stage(wr_stage),
        .wr_all(wr_all), .wr_din(wr_din), .cur_op(cur_op), .cur_ch(cur_ch),
        .zero(zero), .commit(commit), .commit_fld(commit_fld),
        .commit_din(commit_din), .busy(busy), .level(level));

    always #5 clk = ~clk;

    typedef struct { int fld; int op; int ch; int stage; int all; int din; } ent_t;

    // Reference model state
    ent_t m_q[$];
    int   m_cur, m_bc, m_fld, m_din;
    bit   m_zero, m_commit, acc_last;

    int checks = 0, errors = 0;

    task automatic model_reset();
        m_q.delete();
        m_cur = 0; m_bc = 0; m_fld = 0; m_din = 0;
        m_zero = 0; m_commit = 0; acc_last = 0;
    endtask

    // Predict the effect of the coming edge, then advance to just after it.
    task automatic tick();
        ent_t e, n;
        int tgt;
        bit acc;
        acc = wr_valid && (m_q.size() < DEPTH);
        m_commit = 0;
        if (cen) begin
            if (m_q.size() > 0) begin
                e = m_q[0];
                tgt = (e.op * NCH + (e.all != 0 ? m_bc : e.ch) + e.stage) % NSLOT;
                if (tgt == m_cur) begin
                    m_commit = 1; m_fld = e.fld; m_din = e.din;
                    if (e.all == 0 || m_bc == NCH - 1) begin
                        void'(m_q.pop_front());
                        m_bc = 0;
                    end else m_bc++;
                end
            end
            m_zero = (m_cur == NSLOT - 1);
            m_cur = (m_cur + 1) % NSLOT;
        end
        if (acc) begin
            n.fld = int'(wr_fld); n.op = int'(wr_op); n.ch = int'(wr_ch);
            n.stage = int'(wr_stage); n.all = int'(wr_all); n.din = int'(wr_din);
            m_q.push_back(n);
        end
        acc_last = acc;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; wr_valid = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic set_wr(input int fld, input int op, input int ch, input int stg,
                          input int all, input int din);
        wr_fld = FLD_W'(fld); wr_op = OP_W'(op); wr_ch = CH_W'(ch);
        wr_stage = STG_W'(stg); wr_all = all[0]; wr_din = DW'(din); wr_valid = 1;
    endtask

    task automatic push_one(input int fld, input int op, input int ch, input int stg,
                            input int all, input int din);
        set_wr(fld, op, ch, stg, all, din);
        tick();
        wr_valid = 0;
    endtask

    // Advance until a commit appears (bounded); slot is cur before that edge.
    task automatic wait_commit(input int max, output int slot, output bit seen);
        int pre;
        seen = 0; slot = -1;
        for (int i = 0; i < max && !seen; i++) begin
            pre = int'({cur_op, cur_ch});
            tick();
            if (commit) begin seen = 1; slot = pre; end
        end
    endtask

    task automatic test_reset();
        cen = 0;
        do_reset();
        checks++; if ({cur_op, cur_ch} !== '0) begin errors++; $display("FAIL reset_cur got %0d exp 0", {cur_op, cur_ch}); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp 0", zero); end
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL reset_commit got %b exp 0", commit); end
        checks++; if (commit_fld !== '0 || commit_din !== '0) begin errors++; $display("FAIL reset_commit_data got %h/%h exp 0/0", commit_fld, commit_din); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    endtask

    task automatic test_slot_counter();
        int bad = 0;
        cen = 1;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            tick();
            checks++;
            if (int'({cur_op, cur_ch}) !== n % NSLOT || zero !== (n % NSLOT == 0)) begin
                errors++;
                if (bad++ < 5) $display("FAIL slot_counter step %0d got cur %0d zero %b exp cur %0d zero %b",
                                         n, {cur_op, cur_ch}, zero, n % NSLOT, (n % NSLOT == 0));
            end
        end
        // cen low freezes the slot counter
        cen = 0;
        tick(); tick();
        checks++; if (int'({cur_op, cur_ch}) !== 40 % NSLOT) begin errors++; $display("FAIL cen_hold got %0d exp %0d", {cur_op, cur_ch}, 40 % NSLOT); end
    endtask

    task automatic test_unicast();
        int slot; bit seen;
        cen = 1;
        do_reset();
        repeat (3) tick();
        checks++; if (int'({cur_op, cur_ch}) !== 3) begin errors++; $display("FAIL unicast_start got %0d exp 3", {cur_op, cur_ch}); end
        push_one(4'h6, 1, 2, 0, 0, 8'h5A);
        checks++; if (level !== 1 || busy !== 1'b1) begin errors++; $display("FAIL unicast_queued got level %0d busy %b exp 1/1", level, busy); end
        wait_commit(2 * NSLOT, slot, seen);
        checks++; if (!seen || slot != 10) begin errors++; $display("FAIL unicast_slot got %0d exp 10", slot); end
        checks++; if (commit_din !== 8'h5A || commit_fld !== 4'h6) begin errors++; $display("FAIL unicast_data got %h/%h exp 6/5a", commit_fld, commit_din); end
        checks++; if (level !== 0 || busy !== 1'b1) begin errors++; $display("FAIL unicast_pop got level %0d busy %b exp 0/1", level, busy); end
        tick();
        checks++; if (busy !== 1'b0 || commit !== 1'b0) begin errors++; $display("FAIL unicast_idle got busy %b commit %b exp 0/0", busy, commit); end
        checks++; if (commit_din !== 8'h5A) begin errors++; $display("FAIL unicast_hold got %h exp 5a", commit_din); end
    endtask

    task automatic test_wrap();
        int slot; bit seen;
        cen = 1;
        push_one(4'h2, 3, 7, 2, 0, 8'hC3);
        wait_commit(2 * NSLOT, slot, seen);
        checks++; if (!seen || slot != 1) begin errors++; $display("FAIL wrap_slot got %0d exp 1", slot); end
        checks++; if (commit_din !== 8'hC3) begin errors++; $display("FAIL wrap_data got %h exp c3", commit_din); end
    endtask

    task automatic test_broadcast();
        int slot, pre; bit seen;
        cen = 1;
        push_one(4'h9, 2, 0, 1, 1, 8'h33);
        wait_commit(2 * NSLOT, slot, seen);
        checks++; if (!seen || slot != 17) begin errors++; $display("FAIL bcast_first got %0d exp 17", slot); end
        for (int k = 1; k < NCH; k++) begin
            pre = int'({cur_op, cur_ch});
            tick();
            checks++;
            if (commit !== 1'b1 || pre != 17 + k || commit_din !== 8'h33 || commit_fld !== 4'h9) begin
                errors++;
                $display("FAIL bcast_seq k=%0d got commit %b slot %0d din %h exp 1/%0d/33", k, commit, pre, commit_din, 17 + k);
            end
            checks++;
            if (level !== (k == NCH - 1 ? 0 : 1)) begin errors++; $display("FAIL bcast_level k=%0d got %0d", k, level); end
        end
        tick();
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL bcast_end got commit %b exp 0", commit); end
    endtask

    task automatic test_full();
        int got[$];
        int exp_din[5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        bit accepted = 0;
        cen = 0;
        do_reset();
        push_one(1, 0, 5, 0, 0, exp_din[0]);
        push_one(2, 1, 1, 0, 0, exp_din[1]);
        push_one(3, 1, 5, 0, 0, exp_din[2]);
        push_one(4, 2, 4, 0, 0, exp_din[3]);
        set_wr(5, 0, 2, 0, 0, exp_din[4]);
        tick();
        checks++; if (wr_ready !== 1'b0 || level !== 4) begin errors++; $display("FAIL full got ready %b level %0d exp 0/4", wr_ready, level); end
        checks++; if (acc_last) begin errors++; $display("FAIL full_model_accept got 1 exp 0"); end
        cen = 1;
        for (int i = 0; i < 4 * NSLOT && got.size() < 5; i++) begin
            tick();
            if (commit) got.push_back(int'(commit_din));
            if (acc_last && !accepted) begin
                accepted = 1;
                wr_valid = 0;
                checks++; if (level !== 4 || got.size() != 1) begin errors++; $display("FAIL full_refill got level %0d commits %0d exp 4/1", level, got.size()); end
            end
        end
        wr_valid = 0;
        checks++; if (!accepted) begin errors++; $display("FAIL full_accept got 0 exp 1"); end
        checks++; if (got.size() != 5) begin errors++; $display("FAIL full_count got %0d exp 5", got.size()); end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            checks++; if (got[i] != exp_din[i]) begin errors++; $display("FAIL full_order idx %0d got %h exp %h", i, got[i], exp_din[i]); end
        end
    endtask

    task automatic test_reset_mid_bcast();
        int slot; bit seen; int stray = 0;
        cen = 1;
        do_reset();
        push_one(4'h1, 1, 0, 0, 1, 8'h77);
        wait_commit(2 * NSLOT, slot, seen);
        tick(); tick();
        checks++; if (!seen || commit !== 1'b1) begin errors++; $display("FAIL rst_bcast_pre got seen %b commit %b exp 1/1", seen, commit); end
        rst = 1;
        model_reset();
        #1;
        checks++; if (commit !== 1'b0 || level !== 0 || {cur_op, cur_ch} !== '0) begin errors++; $display("FAIL rst_async got commit %b level %0d cur %0d exp 0/0/0", commit, level, {cur_op, cur_ch}); end
        @(posedge clk); #1 rst = 0;
        tick();
        checks++; if (commit !== 1'b0 || int'({cur_op, cur_ch}) !== 1) begin errors++; $display("FAIL rst_release got commit %b cur %0d exp 0/1", commit, {cur_op, cur_ch}); end
        for (int i = 0; i < 2 * NSLOT; i++) begin tick(); if (commit) stray++; end
        checks++; if (stray != 0) begin errors++; $display("FAIL rst_discard got %0d commits exp 0", stray); end
        push_one(4'h2, 1, 5, 0, 1, 8'h66);
        wait_commit(2 * NSLOT, slot, seen);
        checks++; if (!seen || slot != 8 || commit_din !== 8'h66) begin errors++; $display("FAIL rst_restart got slot %0d din %h exp 8/66", slot, commit_din); end
    endtask

    task automatic test_random();
        int bad = 0;
        cen = 1;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cen = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 4)
                set_wr($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 7),
                       $urandom_range(0, 7), ($urandom_range(0, 5) == 0), $urandom_range(0, 255));
            else wr_valid = 0;
            tick();
            checks++;
            if (int'({cur_op, cur_ch}) !== m_cur || zero !== m_zero || commit !== m_commit ||
                int'(commit_fld) !== m_fld || int'(commit_din) !== m_din ||
                int'(level) !== m_q.size() || wr_ready !== (m_q.size() < DEPTH) ||
                busy !== (m_q.size() != 0 || m_commit)) begin
                errors++;
                if (bad++ < 10)
                    $display("FAIL random cyc %0d got cur %0d z %b c %b f %h d %h lv %0d rdy %b bsy %b exp cur %0d z %b c %b f %h d %h lv %0d",
                             i, {cur_op, cur_ch}, zero, commit, commit_fld, commit_din, level, wr_ready, busy,
                             m_cur, m_zero, m_commit, m_fld, m_din, m_q.size());
            end
        end
        wr_valid = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_slot_counter();
        test_unicast();
        test_wrap();
        test_broadcast();
        test_full();
        test_reset_mid_bcast();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
